systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Upstream feeder for the N×N systolic MAC array built from `pe` tiles. It buffers one tile of operands:
- A columns: one int8 per array row per beat.
- B rows: one int8 per array column per beat.

On `start` it pulses a PE accumulator clear, then streams the operands into the array's west and north edges with the diagonal skew the array needs. It signals `done` on the first cycle every PE accumulator holds its final dot product.

## Interface
Parameters:
- `N`, 4: array dimension (lanes per edge).
- `K_MAX`, 16: maximum inner dimension (buffer depth).
- `DATA_W`, 8: signed operand width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  feeder can accept a load beat.
- `ld_a`  in  N*DATA_W  A[i][k] for row i, lane i at bits [8i+7:8i].
- `ld_b`  in  N*DATA_W  B[k][j] for column j, lane j at bits [8j+7:8j].
- `ld_last`  in  1  beat is the final k of the tile.
- `start`  in  1  begin streaming the loaded tile.
- `busy`  out  1  high in CLEAR, STREAM and FLUSH.
- `pe_clr`  out  1  one-cycle clear, ORed into every PE reset.
- `a_out`  out  N*DATA_W  west-edge operands, lane i feeds row i.
- `b_out`  out  N*DATA_W  north-edge operands, lane j feeds column j.
- `done`  out  1  one-cycle pulse: array results final.

## Operation
States are IDLE, LOADED, CLEAR, STREAM, FLUSH.

- **Load handshake:** a beat transfers when `ld_valid && ld_ready`. `ld_ready` = (state==IDLE). Beat n is written to buffer entry n and `k_cnt` increments.
- **IDLE → LOADED:** on a transferring beat with `ld_last`=1, or on the beat that makes `k_cnt`==K_MAX.
- **LOADED → CLEAR:** on `start`. `start` is ignored in every other state, including the cycle in which `ld_last` transfers.
- **CLEAR** (1 cycle): `pe_clr`=1, `a_out`/`b_out`=0.
- **STREAM** lasts K+N−1 cycles, where K=`k_cnt`. Stream cycle c runs from 0 to K+N−2.
  - `a_out` lane i = A[i][c−i] when 0≤c−i<K, otherwise 0.
  - `b_out` lane j = B[c−j][j] under the same rule.
- **FLUSH** lasts N−1 cycles with all lanes 0. It exits to IDLE with `done`=1 for that single cycle and clears `k_cnt`.
- **Passthrough:** operand values pass through unmodified, −128 included. No arithmetic is done in the feeder.
- **Reset** at any time, including mid-STREAM: next cycle state=IDLE, `k_cnt`=0, and all outputs 0 except `ld_ready`=1. Buffer contents are don't-care.
- **Reset values:** `ld_ready`=1; `busy`, `pe_clr`, `done`, `a_out`, `b_out` = 0.

## Timing
- All outputs are registered.
- Take t0 = first STREAM cycle. `pe_clr` is high in cycle t0−1, which is the cycle after `start` is sampled.
- PE(i,j) accumulates A[i][k]·B[k][j] at the end of cycle t0+k+i+j.
- The last MAC occurs at the end of cycle t0+K+2N−3.
- `done` is high in cycle t0+K+2N−2. `busy` falls in that same cycle.
- Start-to-done latency: K+2N−1 cycles after the `start` sample edge.
- The earliest next load beat is accepted in the `done` cycle.

## Configuration
- `FEEDER_PERF_EN` defined:
  - adds output `perf_tiles` (32-bit): increments on each `done`.
  - adds output `perf_busy_cycles` (32-bit): increments every cycle `busy`=1.
  - Both counters are zeroed by `reset` and wrap at 2^32.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- Package `pe_pkg`:
  - `DATA_W`=8, `ACC_W`=32.
  - `feeder_state_t` enum.
  - a `lane_t` signed [DATA_W-1:0] typedef.
- Sub-module `skew_delay`: parameter DEPTH; a DEPTH-stage shift register of `lane_t`, with DEPTH=0 as a wire. Instantiated per lane with DEPTH=i. The feeder reads buffer row c (or zero when c≥K) and drives each lane through its `skew_delay`.

## Test plan
1. **Single-beat tile.** N=4. Load one beat with `ld_last`, ld_a={1,2,3,4}, ld_b={5,6,7,8}, then `start` → `a_out` lane i is nonzero only at stream cycle i. With an attached 4×4 `pe` array, C[3][3]=32 and C[0][2]=7 hold at the `done` cycle, which is `start`+8.
2. **Full buffer.** Send 16 beats without `ld_last` → `ld_ready` drops after beat 16 and state is LOADED. `start` → `done` at `start`+23.
3. **Illegal requests ignored.** `start` in IDLE, and `start` on the `ld_last` beat → no `pe_clr`. `ld_valid` during `busy` → not accepted, and `k_cnt` is unchanged.
4. **Reset mid-stream.** Assert `reset` at stream cycle 3 → next cycle all outputs are 0 and `ld_ready`=1. A new tile loaded afterwards computes correctly.
5. **Extreme operands.** All A and B operands = −128, K=2 → lanes carry 8'h80 unchanged, and every C[i][j]=32768.
6. **Performance counters.** With `FEEDER_PERF_EN`, run two K=1 tiles back-to-back → `perf_tiles`=2 and `perf_busy_cycles`=16.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the pe systolic MAC array and its operand feeder.
package pe_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef logic signed [DATA_W-1:0] lane_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADED,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH
    } feeder_state_t;

endpackage

// File: rtl/skew_delay.sv
// DEPTH-stage shift register of one operand lane; DEPTH=0 degenerates to a wire.
module skew_delay
    import pe_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic  clk,
    input  logic  reset,
    input  lane_t din,
    output lane_t dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = clk ^ reset;
        assign dout = din;
    end else begin : g_shift
        lane_t stage_p [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < DEPTH; s++) stage_p[s] <= '0;
            end else begin
                stage_p[0] <= din;
                for (int s = 1; s < DEPTH; s++) stage_p[s] <= stage_p[s-1];
            end
        end

        assign dout = stage_p[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one operand tile and streams it diagonally skewed into an NxN systolic MAC array.
// Defining FEEDER_PERF_EN adds the perf_tiles / perf_busy_cycles counters.
module systolic_feeder #(
    parameter int N      = 4,
    parameter int K_MAX  = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [N*DATA_W-1:0] ld_a,
    input  logic [N*DATA_W-1:0] ld_b,
    input  logic                ld_last,
    input  logic                start,
    output logic                busy,
    output logic                pe_clr,
    output logic [N*DATA_W-1:0] a_out,
    output logic [N*DATA_W-1:0] b_out,
    output logic                done
`ifdef FEEDER_PERF_EN
    ,
    output logic [31:0]         perf_tiles,
    output logic [31:0]         perf_busy_cycles
`endif
);

    import pe_pkg::*;

    localparam int CNT_W = $clog2(K_MAX + N + 1);
    localparam int AW    = $clog2(K_MAX);

    feeder_state_t    state, state_nxt;
    logic [CNT_W-1:0] k_cnt, cyc, rd_idx;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic             accept, feed_en;
    logic             ld_ready_d, busy_d, pe_clr_d, done_d;

    lane_t buf_a [K_MAX][N];
    lane_t buf_b [K_MAX][N];
    lane_t src_a_p0 [N];
    lane_t src_b_p0 [N];
    lane_t dly_a [N];
    lane_t dly_b [N];

    assign accept  = ld_valid && (state == ST_IDLE);
    assign wr_addr = k_cnt[AW-1:0];
    assign rd_addr = rd_idx[AW-1:0];
    assign feed_en = ((state == ST_CLEAR) || (state == ST_STREAM)) && (rd_idx < k_cnt);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && (ld_last || (k_cnt == CNT_W'(K_MAX - 1)))) state_nxt = ST_LOADED;
            ST_LOADED: if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_STREAM;
            ST_STREAM: if (cyc == k_cnt + CNT_W'(N - 2)) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (cyc == CNT_W'(N - 2)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with it.
    always_comb begin
        ld_ready_d = (state_nxt == ST_IDLE);
        busy_d     = (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM) || (state_nxt == ST_FLUSH);
        pe_clr_d   = (state_nxt == ST_CLEAR);
        done_d     = (state == ST_FLUSH) && (state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_ready <= 1'b1;
            busy     <= 1'b0;
            pe_clr   <= 1'b0;
            done     <= 1'b0;
        end else begin
            ld_ready <= ld_ready_d;
            busy     <= busy_d;
            pe_clr   <= pe_clr_d;
            done     <= done_d;
        end
    end

    // rd_idx runs from 0 in CLEAR so row m enters the delay lines one cycle before stream cycle m.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_cnt  <= '0;
            cyc    <= '0;
            rd_idx <= '0;
        end else begin
            if (accept)      k_cnt <= k_cnt + 1'b1;
            else if (done_d) k_cnt <= '0;

            if (state_nxt != state)                             cyc <= '0;
            else if ((state == ST_STREAM) || (state == ST_FLUSH)) cyc <= cyc + 1'b1;

            if ((state == ST_CLEAR) || (state == ST_STREAM)) rd_idx <= rd_idx + 1'b1;
            else                                            rd_idx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                buf_a[wr_addr][i] <= ld_a[i*DATA_W +: DATA_W];
                buf_b[wr_addr][i] <= ld_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_a_p0[i] = feed_en ? buf_a[rd_addr][i] : '0;
            src_b_p0[i] = feed_en ? buf_b[rd_addr][i] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay #(.DEPTH(i)) u_skew_a (
            .clk  (clk),
            .reset(reset),
            .din  (src_a_p0[i]),
            .dout (dly_a[i])
        );
        skew_delay #(.DEPTH(i)) u_skew_b (
            .clk  (clk),
            .reset(reset),
            .din  (src_b_p0[i]),
            .dout (dly_b[i])
        );
    end

    // Final output register stage on every lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                a_out[i*DATA_W +: DATA_W] <= dly_a[i];
                b_out[i*DATA_W +: DATA_W] <= dly_b[i];
            end
        end
    end

`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_tiles       <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (done) perf_tiles       <= perf_tiles + 32'd1;
            if (busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: table of tiles streamed into a behavioural 4x4 MAC array model.
module tb_systolic_feeder;

    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset, ld_valid, ld_last, start;
    logic [N*DW-1:0] ld_a, ld_b, a_out, b_out;
    logic          ld_ready, busy, pe_clr, done;
`ifdef FEEDER_PERF_EN
    logic [31:0]   perf_tiles, perf_busy_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    systolic_feeder #(.N(N), .K_MAX(K_MAX), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_a            (ld_a),
        .ld_b            (ld_b),
        .ld_last         (ld_last),
        .start           (start),
        .busy            (busy),
        .pe_clr          (pe_clr),
        .a_out           (a_out),
        .b_out           (b_out),
        .done            (done)
`ifdef FEEDER_PERF_EN
        ,
        .perf_tiles      (perf_tiles),
        .perf_busy_cycles(perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array: a flows east, b flows south, pe_clr clears everything.
    logic signed [7:0] pa [N][N], pb [N][N], ain [N][N], bin [N][N];
    int acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ain[i][j] = (j == 0) ? a_out[8*i +: 8] : pa[i][(j > 0) ? j-1 : 0];
                bin[i][j] = (i == 0) ? b_out[8*j +: 8] : pb[(i > 0) ? i-1 : 0][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_clr) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                end
            end
        end
    end

    typedef struct {
        int k;
        int mode;
        bit use_last;
        bit start_on_last;
        bit junk;
        int exp_lat;
        int exp_c02;
        int exp_c33;
    } vec_t;

    vec_t vecs [5];

    function automatic int op_a(int mode, int i, int k);
        case (mode)
            0:       return i + 1 + k;
            1:       return -128;
            2:       return 3*i - k + 1;
            default: return k - 8 + i;
        endcase
    endfunction

    function automatic int op_b(int mode, int k, int j);
        case (mode)
            0:       return j + 5 + k;
            1:       return -128;
            2:       return k - 2*j;
            default: return j - k;
        endcase
    endfunction

    function automatic logic [N*DW-1:0] pack_a(int mode, int k);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[8*i +: 8] = 8'(op_a(mode, i, k));
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack_b(int mode, int k);
        logic [N*DW-1:0] r;
        for (int j = 0; j < N; j++) r[8*j +: 8] = 8'(op_b(mode, k, j));
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_a_bus(int mode, int kk, int c);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++)
            r[8*i +: 8] = (c - i >= 0 && c - i < kk) ? 8'(op_a(mode, i, c - i)) : 8'h00;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_b_bus(int mode, int kk, int c);
        logic [N*DW-1:0] r;
        for (int j = 0; j < N; j++)
            r[8*j +: 8] = (c - j >= 0 && c - j < kk) ? 8'(op_b(mode, c - j, j)) : 8'h00;
        return r;
    endfunction

    function automatic int exp_c(int mode, int kk, int i, int j);
        int s = 0;
        for (int k = 0; k < kk; k++) s += op_a(mode, i, k) * op_b(mode, k, j);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tile(input vec_t v);
        for (int k = 0; k < v.k; k++) begin
            check("ld_ready_beat", ld_ready, 1'b1);
            ld_valid = 1'b1;
            ld_a     = pack_a(v.mode, k);
            ld_b     = pack_b(v.mode, k);
            ld_last  = v.use_last && (k == v.k - 1);
            start    = v.start_on_last && (k == v.k - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b0;
        check("ld_ready_loaded", ld_ready, 1'b0);
        if (v.start_on_last) check("start_on_last_ignored", pe_clr, 1'b0);
    endtask

    task automatic stream_tile(input vec_t v);
        int lat = 0;
        bit seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pe_clr_pulse", pe_clr, 1'b1);
        check("busy_clear", busy, 1'b1);
        check("clear_lanes", {a_out, b_out}, 64'd0);
        if (v.junk) begin
            ld_valid = 1'b1;
            ld_last  = 1'b1;
            ld_a     = '1;
            ld_b     = '1;
        end
        for (int n = 1; n <= 60 && !seen; n++) begin
            tick();
            lat = n;
            if (n == 4) begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                check("a_stream", a_out, exp_a_bus(v.mode, v.k, n - 1));
                check("b_stream", b_out, exp_b_bus(v.mode, v.k, n - 1));
                check("busy_run", busy, 1'b1);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=no_done exp=latency_%0d", v.exp_lat);
        end else begin
            check("done_latency", lat, v.exp_lat);
            check("busy_at_done", busy, 1'b0);
            check("ld_ready_at_done", ld_ready, 1'b1);
            check("c02", acc[0][2], v.exp_c02);
            check("c33", acc[3][3], v.exp_c33);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    check("c_matrix", acc[i][j], exp_c(v.mode, v.k, i, j));
        end
        tick();
        check("done_pulse", done, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b0;
        ld_a     = '0;
        ld_b     = '0;

        //           k  mode last sol junk lat  c02    c33
        vecs[0] = '{ 1, 0,   1,   0,  0,   8,   7,     32   };
        vecs[1] = '{ 2, 1,   1,   0,  0,   9,   32768, 32768};
        vecs[2] = '{ 3, 2,   1,   1,  0,   10,  -2,    -137 };
        vecs[3] = '{16, 3,   0,   0,  0,   23,  -296,  -520 };
        vecs[4] = '{ 5, 0,   1,   0,  1,   12,  145,   310  };

        tick();
        tick();
        reset = 1'b0;
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pe_clr", pe_clr, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lanes", {a_out, b_out}, 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_idle_ignored", pe_clr, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("ld_ready_idle", ld_ready, 1'b1);

        for (int v = 0; v < 5; v++) begin
            load_tile(vecs[v]);
            tick();
            check("pe_clr_loaded_wait", pe_clr, 1'b0);
            check("ld_ready_loaded_wait", ld_ready, 1'b0);
            stream_tile(vecs[v]);
        end

        load_tile(vecs[2]);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ld_ready", ld_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pe_clr", pe_clr, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_lanes", {a_out, b_out}, 64'd0);
        load_tile(vecs[0]);
        stream_tile(vecs[0]);

`ifdef FEEDER_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("perf_tiles_rst", perf_tiles, 32'd0);
        check("perf_busy_rst", perf_busy_cycles, 32'd0);
        load_tile(vecs[0]);
        stream_tile(vecs[0]);
        load_tile(vecs[0]);
        stream_tile(vecs[0]);
        check("perf_tiles", perf_tiles, 32'd2);
        check("perf_busy_cycles", perf_busy_cycles, 32'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
